turbo_llr_loader: RTL and testbench

Upstream frame assembler for `turbo_decode`:
- Accepts a serial stream of channel soft values (LLRs) over a valid/ready handshake.
- Places each sample into the `y[STREAMS][SYMBOLS]` array layout the decoder expects.
- Presents a completed frame with a single-cycle `out_valid` pulse, which drives the decoder's `in_valid`.
- Ping-pong banking lets frame k+1 load while frame k stays stable on `y`.

---
 rtl/turbo_llr_loader_if.sv | 12 +
 rtl/turbo_llr_loader.sv | 154 +++++++++++++++
 tb/tb_turbo_llr_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/turbo_llr_loader_if.sv
// Sample stream into turbo_llr_loader: soft value plus valid/ready handshake and frame marker.
interface turbo_llr_loader_if #(
    parameter int unsigned BITS = 16
);
    logic            s_valid;
    logic            s_ready;
    logic [BITS-1:0] s_data;
    logic            s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/turbo_llr_loader.sv
// Ping-pong LLR frame assembler feeding turbo_decode.y; symbol-major input order.
// Optional s_last framing check (LOAD/FLUSH FSM, frame_err) enabled by TURBO_LLR_LAST_CHECK_EN.
module turbo_llr_loader #(
    parameter int unsigned BITS      = 16,
    parameter int unsigned N         = 64,
    parameter int unsigned NOUT      = 2,
    parameter int unsigned TAIL_BITS = 0,
    localparam int unsigned STREAMS  = 1 + 2 * (NOUT - 1),
    localparam int unsigned SYMBOLS  = N + TAIL_BITS
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    turbo_llr_loader_if.slave                        s,
    output logic [STREAMS-1:0][SYMBOLS-1:0][BITS-1:0] y,
    output logic                                     out_valid,
    output logic                                     frame_err,
    output logic [15:0]                              frame_cnt
);
    localparam int unsigned SW = (STREAMS > 1) ? $clog2(STREAMS) : 1;
    localparam int unsigned KW = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;

    typedef logic [STREAMS-1:0][SYMBOLS-1:0][BITS-1:0] frame_t;

    frame_t        bank_q [2];
    logic          wr_bank_q, wr_bank_d;
    logic [SW-1:0] s_idx_q, s_idx_d, s_inc;
    logic [KW-1:0] k_idx_q, k_idx_d, k_inc;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          ready_q, out_valid_q, out_valid_d;
    logic          wr_en, accept, at_end;

`ifdef TURBO_LLR_LAST_CHECK_EN
    typedef enum logic [0:0] {StLoad, StFlush} state_e;
    state_e state_q, state_d;
    logic   frame_err_q, frame_err_d;
`endif

    assign accept    = s.s_valid && ready_q;
    assign at_end    = (s_idx_q == SW'(STREAMS - 1)) && (k_idx_q == KW'(SYMBOLS - 1));
    assign s.s_ready = ready_q;

    // Position of the next sample when the frame does not end here.
    always_comb begin
        s_inc = s_idx_q + 1'b1;
        k_inc = k_idx_q;
        if (s_idx_q == SW'(STREAMS - 1)) begin
            s_inc = '0;
            k_inc = k_idx_q + 1'b1;
        end
    end

    always_comb begin
        s_idx_d     = s_idx_q;
        k_idx_d     = k_idx_q;
        wr_bank_d   = wr_bank_q;
        frame_cnt_d = frame_cnt_q;
        out_valid_d = 1'b0;
        wr_en       = 1'b0;
`ifdef TURBO_LLR_LAST_CHECK_EN
        state_d     = state_q;
        frame_err_d = 1'b0;
        if (accept) begin
            unique case (state_q)
                StLoad: begin
                    wr_en = 1'b1;
                    if (at_end && s.s_last) begin
                        wr_bank_d   = ~wr_bank_q;
                        s_idx_d     = '0;
                        k_idx_d     = '0;
                        out_valid_d = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else if (at_end || s.s_last) begin
                        // Partial data left in the write bank is harmless: fully rewritten next frame.
                        frame_err_d = 1'b1;
                        s_idx_d     = '0;
                        k_idx_d     = '0;
                        if (!s.s_last) state_d = StFlush;
                    end else begin
                        s_idx_d = s_inc;
                        k_idx_d = k_inc;
                    end
                end
                StFlush: begin
                    if (s.s_last) state_d = StLoad;
                end
                default: state_d = StLoad;
            endcase
        end
`else
        if (accept) begin
            wr_en = 1'b1;
            if (at_end) begin
                wr_bank_d   = ~wr_bank_q;
                s_idx_d     = '0;
                k_idx_d     = '0;
                out_valid_d = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                s_idx_d = s_inc;
                k_idx_d = k_inc;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            wr_bank_q   <= 1'b0;
            s_idx_q     <= '0;
            k_idx_q     <= '0;
            frame_cnt_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ready_q     <= 1'b1;
            wr_bank_q   <= wr_bank_d;
            s_idx_q     <= s_idx_d;
            k_idx_q     <= k_idx_d;
            frame_cnt_q <= frame_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
        end else if (wr_en) begin
            bank_q[wr_bank_q][s_idx_q][k_idx_q] <= s.s_data;
        end
    end

`ifdef TURBO_LLR_LAST_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    logic unused_last;
    assign unused_last = s.s_last;
    assign frame_err   = 1'b0;
`endif

    assign y         = bank_q[~wr_bank_q];
    assign out_valid = out_valid_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_turbo_llr_loader.sv
// Scoreboard bench for turbo_llr_loader: a frame-level model predicts every out_valid/frame_err
// event; a negedge monitor pops and compares, and also watches that y holds between events.
module tb_turbo_llr_loader;
    localparam int BITS      = 16;
    localparam int N         = 64;
    localparam int NOUT      = 2;
    localparam int TAIL_BITS = 0;
    localparam int STREAMS   = 1 + 2 * (NOUT - 1);
    localparam int SYMBOLS   = N + TAIL_BITS;
    localparam int FRAME     = STREAMS * SYMBOLS;
    localparam int SWB       = $clog2(STREAMS);
    localparam int KWB       = $clog2(SYMBOLS);

    typedef logic [STREAMS-1:0][SYMBOLS-1:0][BITS-1:0] y_t;
    typedef struct {
        bit          is_err;
        y_t          y;
        logic [15:0] cnt;
    } ev_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    y_t          y;
    logic        out_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    ev_t             exp_q[$];
    logic [BITS-1:0] cur[$];
    bit              flushing  = 1'b0;
    logic [15:0]     model_cnt = '0;
    y_t              cur_y     = '0;
    y_t              zero_y    = '0;
    bit              hold_bad  = 1'b0;

    turbo_llr_loader_if #(.BITS(BITS)) lif ();

    turbo_llr_loader #(
        .BITS      (BITS),
        .N         (N),
        .NOUT      (NOUT),
        .TAIL_BITS (TAIL_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (lif),
        .y         (y),
        .out_valid (out_valid),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void check_y(input string name, input y_t act, input y_t exp);
        bit found = 1'b0;
        checks++;
        if (act !== exp) begin
            errors++;
            for (int s = 0; s < STREAMS; s++) begin
                for (int k = 0; k < SYMBOLS; k++) begin
                    if (!found && act[SWB'(s)][KWB'(k)] !== exp[SWB'(s)][KWB'(k)]) begin
                        found = 1'b1;
                        $display("FAIL %s: y[%0d][%0d] got %0h expected %0h", name, s, k,
                                 act[SWB'(s)][KWB'(k)], exp[SWB'(s)][KWB'(k)]);
                    end
                end
            end
        end
    endfunction

    // Frame-level reference: sample j lands at stream j mod STREAMS, symbol j div STREAMS.
    function automatic void model_accept(input logic [BITS-1:0] d, input logic l);
        ev_t e;
        e.is_err = 1'b0;
        e.y      = '0;
        e.cnt    = model_cnt;
`ifdef TURBO_LLR_LAST_CHECK_EN
        if (flushing) begin
            if (l) flushing = 1'b0;
            return;
        end
`endif
        cur.push_back(d);
        if (cur.size() == FRAME) begin
`ifdef TURBO_LLR_LAST_CHECK_EN
            if (!l) begin
                e.is_err = 1'b1;
                exp_q.push_back(e);
                cur.delete();
                flushing = 1'b1;
                return;
            end
`endif
            model_cnt = model_cnt + 16'd1;
            e.cnt     = model_cnt;
            for (int j = 0; j < FRAME; j++) e.y[SWB'(j % STREAMS)][KWB'(j / STREAMS)] = cur[j];
            exp_q.push_back(e);
            cur.delete();
        end
`ifdef TURBO_LLR_LAST_CHECK_EN
        else if (l) begin
            e.is_err = 1'b1;
            exp_q.push_back(e);
            cur.delete();
        end
`endif
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            cur_y    = '0;
            hold_bad = 1'b0;
        end else if (out_valid || frame_err) begin
            check("y_hold_between_events", 32'(hold_bad), 32'(0));
            hold_bad = 1'b0;
            if (out_valid && frame_err) check("out_valid_and_frame_err", 32'(1), 32'(0));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: out_valid=%0b frame_err=%0b expected none",
                         out_valid, frame_err);
            end else begin
                e = exp_q.pop_front();
                check("event_frame_err", 32'(frame_err), 32'(e.is_err));
                check("event_out_valid", 32'(out_valid), 32'(!e.is_err));
                if (!e.is_err) begin
                    check_y("frame_y", y, e.y);
                    check("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
                    cur_y = e.y;
                end else begin
                    check_y("y_after_err", y, cur_y);
                end
            end
        end else if (y !== cur_y) begin
            hold_bad = 1'b1;
        end
    end

    task automatic send(input logic [BITS-1:0] d, input logic l);
        int n = 0;
        lif.s_valid = 1'b1;
        lif.s_data  = d;
        lif.s_last  = l;
        while (!lif.s_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("s_ready", 32'(lif.s_ready), 32'(1));
        if (lif.s_ready) begin
            @(posedge clk);
            #1;
            model_accept(d, l);
        end
        lif.s_valid = 1'b0;
        lif.s_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input int last_at, input int gap_pct,
                              input bit rnd, input int base);
        for (int j = 0; j < len; j++) begin
            for (int g = 0; g < 8 && int'($urandom_range(99)) < gap_pct; g++) begin
                @(posedge clk);
                #1;
            end
            send(rnd ? BITS'($urandom) : BITS'(base + j), j == last_at);
        end
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        lif.s_valid = 1'b0;
        lif.s_last  = 1'b0;
        cur.delete();
        flushing  = 1'b0;
        model_cnt = '0;
        #1;
        check("rst_s_ready", 32'(lif.s_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_frame_err", 32'(frame_err), 32'(0));
        check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        check_y("rst_y", y, zero_y);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("s_ready_before_sync", 32'(lif.s_ready), 32'(0));
        @(posedge clk);
        #1;
        check("s_ready_after_sync", 32'(lif.s_ready), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        lif.s_valid = 1'b0;
        lif.s_data  = '0;
        lif.s_last  = 1'b0;
        #2;
        apply_reset();

        // Counting pattern, then back-to-back second frame.
        send_frame(FRAME, FRAME - 1, 0, 1'b0, 0);
        send_frame(FRAME, FRAME - 1, 0, 1'b0, 1000);

        // Random data and ~50% valid gaps.
        repeat (2) send_frame(FRAME, FRAME - 1, 50, 1'b1, 0);
        send_frame(FRAME, FRAME - 1, 50, 1'b0, 3000);

`ifdef TURBO_LLR_LAST_CHECK_EN
        send_frame(101, 100, 0, 1'b0, 500);
        send_frame(FRAME, FRAME - 1, 0, 1'b0, 4000);
        send_frame(FRAME + 4, FRAME + 3, 0, 1'b0, 600);
        send_frame(FRAME, FRAME - 1, 20, 1'b1, 0);
`endif

        // Reset at sample 50 of a frame, then a clean frame.
        send_frame(50, -1, 0, 1'b0, 7000);
        apply_reset();
        send_frame(FRAME, FRAME - 1, 0, 1'b0, 2000);

        repeat (4) @(posedge clk);
        #1;
        check("events_drained", 32'(exp_q.size()), 32'(0));
        check("y_hold_at_end", 32'(hold_bad), 32'(0));
        check("final_frame_cnt", 32'(frame_cnt), 32'(model_cnt));
        check_y("final_y", y, cur_y);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
